block_accumulator: RTL

Sums consecutive blocks of 2^DIV_LOG2 input samples and presents each block sum on a valid/ready output. Sits directly upstream of the round-to-nearest divide-by-2^DIV_LOG2 stage; its `sum` output is exactly that stage's input width, so the pair forms a block averager. Arithmetic is exact, with no overflow and no saturation inside this block.

---
 rtl/block_accumulator.sv | 100 ++++++++++
 1 files changed

// File: rtl/block_accumulator.sv
// block_accumulator
// Sums consecutive blocks of N = 2**DIV_LOG2 unsigned samples and presents each
// block sum through a single-entry valid/ready output register. Feeds the
// round-to-nearest divide-by-N stage, so the pair forms a block averager.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   clear      in   synchronous discard of the partial block
//   din_valid  in   input sample valid
//   din_ready  out  sample accepted this cycle when din_valid is high
//   din        in   DATA_WIDTH unsigned sample
//   sum_valid  out  block sum held and valid
//   sum_ready  in   downstream accepts the sum
//   sum        out  SUM_WIDTH exact block sum
//   fill       out  samples in the current partial block, 0..N-1
module block_accumulator #(
    parameter int DIV_LOG2   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SUM_WIDTH  = DATA_WIDTH + DIV_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic [SUM_WIDTH-1:0]  sum,
    output logic [DIV_LOG2-1:0]   fill
);

    logic [SUM_WIDTH-1:0] acc_q, acc_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [DIV_LOG2-1:0]  fill_q, fill_d;
    logic                 sum_valid_q, sum_valid_d;

    logic                 last_slot;
    logic                 in_beat;
    logic [SUM_WIDTH-1:0] din_ext;
    logic [SUM_WIDTH-1:0] acc_plus;

    // fill counts modulo N, so the last slot of a block is the all-ones value.
    assign last_slot = (fill_q == {DIV_LOG2{1'b1}});

    // Only the closing sample of a block needs room in the output register.
    assign din_ready = !reset && (!last_slot || !sum_valid_q || sum_ready);
    assign in_beat   = din_valid && din_ready;

    assign din_ext  = {{DIV_LOG2{1'b0}}, din};
    assign acc_plus = acc_q + din_ext;

    always_comb begin
        acc_d       = acc_q;
        fill_d      = fill_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;

        if (sum_valid_q && sum_ready) begin
            sum_valid_d = 1'b0;
        end

        if (clear) begin
            // A beat handshaking alongside clear is dropped on purpose.
            acc_d  = '0;
            fill_d = '0;
        end else if (in_beat) begin
            if (last_slot) begin
                // Reload after a same-cycle drain overrides the clear of sum_valid.
                sum_d       = acc_plus;
                sum_valid_d = 1'b1;
                acc_d       = '0;
                fill_d      = '0;
            end else begin
                acc_d  = acc_plus;
                fill_d = fill_q + {{(DIV_LOG2-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            fill_q      <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign fill      = fill_q;

endmodule
